// File: rtl/bisc_sequence_controller_if.sv
// Bundle of the operand-buffer request signals and the PE-array strobes
// around the bit-serial stochastic sequence controller.
interface bisc_sequence_controller_if #(
  parameter int BIN_LEN   = 8,
  parameter int BIN_WIDTH = 3
);
  logic                 start;
  logic                 clear_acc;
  logic [BIN_LEN-1:0]   x_val;
  logic                 abort;
  logic                 ready;
  logic                 pe_init;
  logic                 pe_enable;
  logic [BIN_WIDTH-1:0] selector;
  logic                 zero_select;
  logic                 done;

  // Requester side: issues windows and watches for completion.
  modport master (
    output start, clear_acc, x_val, abort,
    input  ready, pe_init, pe_enable, selector, zero_select, done
  );

  // Controller side: accepts windows and drives the PE strobes.
  modport slave (
    input  start, clear_acc, x_val, abort,
    output ready, pe_init, pe_enable, selector, zero_select, done
  );
endinterface

// File: rtl/bisc_sequence_controller.sv
// Control sequencer for the bit-serial stochastic MVM array. One window of
// x_val cycles walks a phase counter c and selects weight bit
// (BIN_LEN-1 - tz(c)) each cycle, so that bit k is picked 2^k times per
// full period and the PE counters accumulate about x*w/2^BIN_LEN.
module bisc_sequence_controller #(
  parameter int BIN_LEN   = 8,
  parameter int BIN_WIDTH = 3
) (
  input logic clock,
  input logic reset,
  bisc_sequence_controller_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [BIN_LEN-1:0]   c;
  logic [BIN_LEN-1:0]   c_next;
  logic [BIN_LEN-1:0]   rem;
  logic [BIN_LEN-1:0]   rem_next;
  logic [BIN_LEN-1:0]   x_lat;
  logic [BIN_LEN-1:0]   x_lat_next;

  logic                 ready_q;
  logic                 pe_init_q;
  logic                 pe_enable_q;
  logic [BIN_WIDTH-1:0] selector_q;
  logic                 zero_select_q;
  logic                 done_q;

  // Weight-bit index for phase value v: BIN_LEN-1 minus its trailing-zero
  // count. The scan runs from the MSB down, so the lowest set bit wins.
  // v==0 has no meaningful index; zero_select masks that case anyway.
  function automatic logic [BIN_WIDTH-1:0] bit_index(input logic [BIN_LEN-1:0] v);
    logic [BIN_WIDTH-1:0] idx;
    idx = '0;
    for (int i = BIN_LEN - 1; i >= 0; i--) begin
      if (v[i]) idx = BIN_WIDTH'(BIN_LEN - 1 - i);
    end
    return idx;
  endfunction

  // Next-state and datapath update; abort beats the last-RUN-cycle exit.
  always_comb begin
    state_next = state;
    c_next     = c;
    rem_next   = rem;
    x_lat_next = x_lat;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          x_lat_next = bus.x_val;
          rem_next   = bus.x_val;
          c_next     = BIN_LEN'(1);
          if (bus.clear_acc)       state_next = ST_INIT;
          else if (bus.x_val != 0) state_next = ST_RUN;
          else                     state_next = ST_DONE;
        end
      end
      ST_INIT: begin
        if (bus.abort)       state_next = ST_IDLE;
        else if (x_lat == 0) state_next = ST_DONE;
        else                 state_next = ST_RUN;
      end
      ST_RUN: begin
        c_next   = c + BIN_LEN'(1);
        rem_next = rem - BIN_LEN'(1);
        if (bus.abort)                 state_next = ST_IDLE;
        else if (rem == BIN_LEN'(1))   state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      c     <= '0;
      rem   <= '0;
      x_lat <= '0;
    end else begin
      state <= state_next;
      c     <= c_next;
      rem   <= rem_next;
      x_lat <= x_lat_next;
    end
  end

  // Registered output strobes, decoded one cycle ahead from the next state
  // so every output is a flop; outside RUN the PE drive stays neutral.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ready_q       <= 1'b1;
      pe_init_q     <= 1'b0;
      pe_enable_q   <= 1'b0;
      selector_q    <= '0;
      zero_select_q <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      ready_q       <= (state_next == ST_IDLE);
      pe_init_q     <= (state_next == ST_INIT);
      pe_enable_q   <= (state_next == ST_RUN);
      selector_q    <= (state_next == ST_RUN) ? bit_index(c_next) : '0;
      zero_select_q <= (state_next == ST_RUN) ? (c_next == 0) : 1'b1;
      done_q        <= (state_next == ST_DONE);
    end
  end

  assign bus.ready       = ready_q;
  assign bus.pe_init     = pe_init_q;
  assign bus.pe_enable   = pe_enable_q;
  assign bus.selector    = selector_q;
  assign bus.zero_select = zero_select_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_bisc_sequence_controller.sv
// Directed bench for bisc_sequence_controller: window timing, selector
// sequence, zero-length windows, abort, reset mid-window and full-period
// weight reconstruction through a tiny PE model.
module tb_bisc_sequence_controller;

  logic clock;
  logic reset;

  bisc_sequence_controller_if #(.BIN_LEN(8), .BIN_WIDTH(3)) bus ();

  bisc_sequence_controller #(.BIN_LEN(8), .BIN_WIDTH(3)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int total;
  int bad;

  // Results of the most recent observed window.
  int init_cnt;
  int en_cnt;
  int first_en;
  int sel7_cnt;
  int sel0_cnt;
  int sel0_at;
  int zs_bad;
  int model_sum;
  int done_at;
  int ready_after;
  int sel_log[16];

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int got, input int expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a window request for one edge; afterwards we sit in cycle k+1.
  task automatic applyStimulus(input logic clear, input logic [7:0] x);
    bus.start     = 1'b1;
    bus.clear_acc = clear;
    bus.x_val     = x;
    tick();
    bus.start     = 1'b0;
    bus.clear_acc = 1'b0;
    bus.x_val     = 8'd0;
  endtask

  // Follow a window cycle by cycle (cycle 1 = first cycle after accept),
  // feeding a one-PE model with weight w, until done or budget runs out.
  task automatic observeWindow(input logic [7:0] w, input int budget);
    init_cnt = 0; en_cnt = 0; first_en = -1; sel7_cnt = 0; sel0_cnt = 0;
    sel0_at = -1; zs_bad = 0; model_sum = 0; done_at = -1; ready_after = -1;
    for (int i = 0; i < 16; i++) sel_log[i] = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (bus.pe_init) init_cnt++;
      if (bus.pe_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        if (bus.selector == 3'd7) sel7_cnt++;
        if (bus.selector == 3'd0) begin
          sel0_cnt++;
          sel0_at = en_cnt;
        end
        if (bus.zero_select) zs_bad++;
        if (!bus.zero_select && w[bus.selector]) model_sum++;
        if (en_cnt <= 16) sel_log[en_cnt-1] = int'(bus.selector);
      end
      if (bus.done) begin
        done_at = cyc;
        tick();
        ready_after = int'(bus.ready);
        break;
      end
      tick();
    end
  endtask

  initial begin
    int done_seen;
    int en_seen;
    int exp_sel5[5];
    exp_sel5 = '{7, 6, 7, 5, 7};
    total = 0;
    bad   = 0;
    bus.start = 1'b0; bus.clear_acc = 1'b0; bus.x_val = 8'd0; bus.abort = 1'b0;
    reset = 1'b1;

    // Reset values while reset is held.
    #1;
    checkOutput("rst_ready", bus.ready, 1);
    checkOutput("rst_pe_init", bus.pe_init, 0);
    checkOutput("rst_pe_enable", bus.pe_enable, 0);
    checkOutput("rst_selector", bus.selector, 0);
    checkOutput("rst_zero_select", bus.zero_select, 1);
    checkOutput("rst_done", bus.done, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    tick();

    // clear_acc=1, x=5: INIT, five RUN cycles 7,6,7,5,7, done, ready.
    applyStimulus(1'b1, 8'd5);
    checkOutput("a_ready_low", bus.ready, 0);
    observeWindow(8'h00, 40);
    checkOutput("a_init_cnt", init_cnt, 1);
    checkOutput("a_first_en", first_en, 2);
    checkOutput("a_en_cnt", en_cnt, 5);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("a_sel%0d", i), sel_log[i], exp_sel5[i]);
    checkOutput("a_zs_in_run", zs_bad, 0);
    checkOutput("a_done_at", done_at, 7);
    checkOutput("a_ready_after", ready_after, 1);

    // x=255, no clear, weight 0x80: bit 7 on the 128 odd phases.
    applyStimulus(1'b0, 8'd255);
    observeWindow(8'h80, 300);
    checkOutput("b_en_cnt", en_cnt, 255);
    checkOutput("b_first_en", first_en, 1);
    checkOutput("b_sel7_cnt", sel7_cnt, 128);
    checkOutput("b_sel0_cnt", sel0_cnt, 1);
    checkOutput("b_sel0_at", sel0_at, 128);
    checkOutput("b_model", model_sum, 128);
    checkOutput("b_done_at", done_at, 256);
    checkOutput("b_ready_after", ready_after, 1);

    // Back-to-back on the first IDLE cycle, weight 0xA5 rebuilt exactly.
    applyStimulus(1'b0, 8'd255);
    checkOutput("c_accepted", bus.ready, 0);
    observeWindow(8'hA5, 300);
    checkOutput("c_model", model_sum, 165);
    checkOutput("c_en_cnt", en_cnt, 255);
    checkOutput("c_done_at", done_at, 256);

    // Zero-length windows, with and without clear, back to back.
    applyStimulus(1'b1, 8'd0);
    observeWindow(8'hFF, 20);
    checkOutput("d0_init_cnt", init_cnt, 1);
    checkOutput("d0_en_cnt", en_cnt, 0);
    checkOutput("d0_done_at", done_at, 2);
    applyStimulus(1'b0, 8'd0);
    observeWindow(8'hFF, 20);
    checkOutput("d1_init_cnt", init_cnt, 0);
    checkOutput("d1_en_cnt", en_cnt, 0);
    checkOutput("d1_done_at", done_at, 1);
    checkOutput("d1_ready_after", ready_after, 1);

    // Abort at RUN cycle 3 of x=10; a start raised during RUN is dropped.
    applyStimulus(1'b0, 8'd10);
    tick();
    bus.start = 1'b1; bus.x_val = 8'd4;
    tick();
    bus.start = 1'b0; bus.x_val = 8'd0;
    checkOutput("e_run3_enable", bus.pe_enable, 1);
    checkOutput("e_run3_selector", bus.selector, 7);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("e_abort_enable", bus.pe_enable, 0);
    checkOutput("e_abort_ready", bus.ready, 1);
    checkOutput("e_abort_zs", bus.zero_select, 1);
    done_seen = 0; en_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) done_seen++;
      if (bus.pe_enable) en_seen++;
      tick();
    end
    checkOutput("e_no_done", done_seen, 0);
    checkOutput("e_no_queued_start", en_seen, 0);

    // Abort on the last RUN cycle suppresses done.
    applyStimulus(1'b0, 8'd2);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checkOutput("f_last_abort_done", bus.done, 0);
    checkOutput("f_last_abort_ready", bus.ready, 1);
    tick();

    // Reset at RUN cycle 50 of x=200, then a normal x=3 window.
    applyStimulus(1'b0, 8'd200);
    repeat (49) tick();
    checkOutput("g_run50_enable", bus.pe_enable, 1);
    reset = 1'b1;
    #1;
    checkOutput("g_rst_enable", bus.pe_enable, 0);
    checkOutput("g_rst_zs", bus.zero_select, 1);
    checkOutput("g_rst_ready", bus.ready, 1);
    checkOutput("g_rst_done", bus.done, 0);
    #2 reset = 1'b0;
    tick();
    applyStimulus(1'b0, 8'd3);
    observeWindow(8'h00, 20);
    checkOutput("g_en_cnt", en_cnt, 3);
    checkOutput("g_sel0", sel_log[0], 7);
    checkOutput("g_sel1", sel_log[1], 6);
    checkOutput("g_sel2", sel_log[2], 7);
    checkOutput("g_done_at", done_at, 4);
    checkOutput("g_ready_after", ready_after, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
